// File: rtl/timer_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : timer_display_scan
// Description : Frame-latched 8-digit multiplexed seven-segment scan driver
//               for a packed-BCD countdown timer, with edit/done blinking.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_display_scan #(
    parameter int SLOT_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [35:0] bcd_i,
    input  logic        edit_i,
    input  logic [2:0]  curr_digit_i,
    input  logic        done_i,
    output logic [7:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        dp_o
);

    localparam int c_CNT_W = $clog2(SLOT_CYCLES);
    localparam int c_BLK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_SLOT_LAST  = c_CNT_W'(SLOT_CYCLES - 1);
    localparam logic [c_BLK_W-1:0] c_BLINK_LAST = c_BLK_W'(BLINK_CYCLES - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_idx;
    logic [c_BLK_W-1:0] r_blink_cnt;
    logic               r_blink_ph;
    logic [31:0]        r_bcd_snap;
    logic               r_edit_snap;
    logic [2:0]         r_digit_snap;
    logic               r_done_snap;

    logic               w_blank;
    logic               w_edit_hit;
    logic               w_done_hit;
    logic               w_suppress;
    logic [3:0]         w_nib;
    logic [6:0]         w_seg;
    logic               w_dp;
    logic [7:0]         w_an;
    logic               w_unused_lsd;

    // The millisecond-units nibble is never displayed.
    assign w_unused_lsd = ^bcd_i[3:0];

    generate
        if (BLANK_CYCLES > 0) begin : g_blank
            localparam logic [c_CNT_W-1:0] c_BLANK = c_CNT_W'(BLANK_CYCLES);
            assign w_blank = (r_cnt < c_BLANK);
        end else begin : g_no_blank
            assign w_blank = 1'b0;
        end
    endgenerate

    // Display index 7 is h2 (digit 0), so the edited digit sits at 7 - digit.
    assign w_edit_hit = r_edit_snap && (r_digit_snap <= 3'd5) &&
                        (r_idx == (3'd7 - r_digit_snap)) && r_blink_ph;
    assign w_done_hit = r_done_snap && !r_edit_snap && r_blink_ph;
    assign w_suppress = w_blank || w_edit_hit || w_done_hit;

    assign w_nib = r_bcd_snap[{r_idx, 2'b00} +: 4];
    assign w_dp  = !((r_idx == 3'd2) || (r_idx == 3'd4) || (r_idx == 3'd6));
    assign w_an  = ~(8'h01 << r_idx);

    always_comb begin
        w_seg = 7'h3F;
        case (w_nib)
            4'd0:    w_seg = 7'h40;
            4'd1:    w_seg = 7'h79;
            4'd2:    w_seg = 7'h24;
            4'd3:    w_seg = 7'h30;
            4'd4:    w_seg = 7'h19;
            4'd5:    w_seg = 7'h12;
            4'd6:    w_seg = 7'h02;
            4'd7:    w_seg = 7'h78;
            4'd8:    w_seg = 7'h00;
            4'd9:    w_seg = 7'h10;
            default: w_seg = 7'h3F;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_blink_cnt  <= '0;
            r_blink_ph   <= 1'b0;
            r_bcd_snap   <= '0;
            r_edit_snap  <= 1'b0;
            r_digit_snap <= '0;
            r_done_snap  <= 1'b0;
            an_o         <= 8'hFF;
            seg_o        <= 7'h7F;
            dp_o         <= 1'b1;
        end else begin
            if (r_cnt == c_SLOT_LAST) begin
                r_cnt <= '0;
                r_idx <= r_idx + 3'd1;
                // Snapshot only at the frame boundary so a frame never tears.
                if (r_idx == 3'd7) begin
                    r_bcd_snap   <= bcd_i[35:4];
                    r_edit_snap  <= edit_i;
                    r_digit_snap <= curr_digit_i;
                    r_done_snap  <= done_i;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (r_blink_cnt == c_BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_blink_ph  <= ~r_blink_ph;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end

            if (w_suppress) begin
                an_o  <= 8'hFF;
                seg_o <= 7'h7F;
                dp_o  <= 1'b1;
            end else begin
                an_o  <= w_an;
                seg_o <= w_seg;
                dp_o  <= w_dp;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_timer_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_display_scan
// Description : Scoreboard bench for timer_display_scan (8/2/64 cycle config).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_display_scan;

    localparam int SLOT  = 8;
    localparam int BLANK = 2;
    localparam int BLINK = 64;
    localparam int FRAME = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [35:0] bcd_i;
    logic        edit_i;
    logic [2:0]  curr_digit_i;
    logic        done_i;
    logic [7:0]  an_o;
    logic [6:0]  seg_o;
    logic        dp_o;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t        sb[$];
    int          n_pass  = 0;
    int          n_total = 0;

    int          m_j;
    logic [35:0] m_bcd;
    logic        m_edit;
    logic [2:0]  m_dig;
    logic        m_done;

    // Segment codes for digits of 36'h123456789 at display index 0..7.
    logic [6:0]  val_seg [8] = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};

    timer_display_scan #(
        .SLOT_CYCLES (SLOT),
        .BLANK_CYCLES(BLANK),
        .BLINK_CYCLES(BLINK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bcd_i       (bcd_i),
        .edit_i      (edit_i),
        .curr_digit_i(curr_digit_i),
        .done_i      (done_i),
        .an_o        (an_o),
        .seg_o       (seg_o),
        .dp_o        (dp_o)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] nib);
        case (nib)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Expected output on the edge following scan state j (edges since release).
    function automatic exp_t model(input int j);
        int   cnt;
        int   idx;
        bit   ph;
        bit   sup;
        exp_t e;
        cnt = j % SLOT;
        idx = (j / SLOT) % 8;
        ph  = ((j / BLINK) % 2) == 1;
        sup = (cnt < BLANK) ||
              (m_edit && (int'(m_dig) <= 5) && (idx == 7 - int'(m_dig)) && ph) ||
              (m_done && !m_edit && ph);
        if (sup) begin
            e = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1};
        end else begin
            e.an  = ~(8'h01 << idx);
            e.seg = seg_of(m_bcd[4*idx+4 +: 4]);
            e.dp  = !(idx == 2 || idx == 4 || idx == 6);
        end
        return e;
    endfunction

    // Push the expectation for the coming edge, then advance one clock.
    task automatic step();
        exp_t e;
        if (rst) e = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1};
        else     e = model(m_j);
        sb.push_back(e);
        if (rst) begin
            m_j    = 0;
            m_bcd  = '0;
            m_edit = 1'b0;
            m_dig  = '0;
            m_done = 1'b0;
        end else begin
            if (m_j % FRAME == FRAME - 1) begin
                m_bcd  = bcd_i;
                m_edit = edit_i;
                m_dig  = curr_digit_i;
                m_done = done_i;
            end
            m_j++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        int   dp_low;
        rst = 1'b1; bcd_i = '0; edit_i = 1'b0; curr_digit_i = '0; done_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(); e = sb.pop_front();
            n_total++;
            if ({an_o, seg_o, dp_o} !== {8'hFF, 7'h7F, 1'b1})
                $display("FAIL reset k=%0d got %h/%h/%b want FF/7F/1", k, an_o, seg_o, dp_o);
            else n_pass++;
        end
        rst = 1'b0;
        bcd_i = 36'h123456789;
        dp_low = 0;
        for (int k = 0; k < FRAME; k++) begin
            step(); e = sb.pop_front();
            n_total++;
            if ({an_o, seg_o, dp_o} !== e)
                $display("FAIL frame0 k=%0d got %h/%h/%b want %h/%h/%b", k, an_o, seg_o, dp_o, e.an, e.seg, e.dp);
            else n_pass++;
            if (dp_o === 1'b0) dp_low++;
            if (k == 2) begin
                n_total++;
                if (an_o !== 8'hFE || seg_o !== 7'h40)
                    $display("FAIL first_digit got an=%h seg=%h want an=FE seg=40", an_o, seg_o);
                else n_pass++;
            end
        end
        n_total++;
        if (dp_low !== 18) $display("FAIL dp_count got %0d want 18", dp_low);
        else n_pass++;
    endtask

    task automatic test_value();
        exp_t e;
        for (int k = 0; k < FRAME; k++) begin
            step(); e = sb.pop_front();
            n_total++;
            if ({an_o, seg_o, dp_o} !== e)
                $display("FAIL value k=%0d got %h/%h/%b want %h/%h/%b", k, an_o, seg_o, dp_o, e.an, e.seg, e.dp);
            else n_pass++;
            if (k % SLOT >= BLANK) begin
                n_total++;
                if (seg_o !== val_seg[k/SLOT] || dp_o !== !((k/SLOT) inside {2, 4, 6}))
                    $display("FAIL value_seg idx=%0d got seg=%h dp=%b want seg=%h", k/SLOT, seg_o, dp_o, val_seg[k/SLOT]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_tearing();
        exp_t e;
        for (int k = 0; k < 2*FRAME; k++) begin
            if (k == 3*SLOT) bcd_i = '0;
            step(); e = sb.pop_front();
            n_total++;
            if ({an_o, seg_o, dp_o} !== e)
                $display("FAIL tearing k=%0d got %h/%h/%b want %h/%h/%b", k, an_o, seg_o, dp_o, e.an, e.seg, e.dp);
            else n_pass++;
            n_total++;
            if (k % SLOT < BLANK) begin
                if (an_o !== 8'hFF) $display("FAIL blank k=%0d got an=%h want FF", k, an_o);
                else n_pass++;
            end else if (k < FRAME) begin
                if (seg_o !== val_seg[k/SLOT])
                    $display("FAIL tear_old k=%0d got seg=%h want %h", k, seg_o, val_seg[k/SLOT]);
                else n_pass++;
            end else begin
                if (seg_o !== 7'h40) $display("FAIL tear_new k=%0d got seg=%h want 40", k, seg_o);
                else n_pass++;
            end
        end
    endtask

    task automatic test_edit();
        exp_t       e;
        logic [7:0] want_an;
        edit_i = 1'b1; curr_digit_i = 3'd2; bcd_i = 36'h123456789;
        for (int k = 0; k < 4*FRAME; k++) begin
            if (k == 2*FRAME) curr_digit_i = 3'd6;
            step(); e = sb.pop_front();
            n_total++;
            if ({an_o, seg_o, dp_o} !== e)
                $display("FAIL edit k=%0d got %h/%h/%b want %h/%h/%b", k, an_o, seg_o, dp_o, e.an, e.seg, e.dp);
            else n_pass++;
            if (k >= FRAME && k % SLOT >= BLANK) begin
                // Frame 1 of this test blinks idx 5 off; frames 2 and 3 show all digits.
                want_an = ((k / FRAME) == 1 && (k % FRAME) / SLOT == 5) ? 8'hFF : ~(8'h01 << ((k % FRAME) / SLOT));
                n_total++;
                if (an_o !== want_an) $display("FAIL edit_blink k=%0d got an=%h want %h", k, an_o, want_an);
                else n_pass++;
            end
        end
    endtask

    task automatic test_done();
        exp_t       e;
        logic [7:0] want_an;
        edit_i = 1'b0; done_i = 1'b1;
        for (int k = 0; k < 4*FRAME; k++) begin
            if (k == 2*FRAME) begin edit_i = 1'b1; curr_digit_i = 3'd0; end
            step(); e = sb.pop_front();
            n_total++;
            if ({an_o, seg_o, dp_o} !== e)
                $display("FAIL done k=%0d got %h/%h/%b want %h/%h/%b", k, an_o, seg_o, dp_o, e.an, e.seg, e.dp);
            else n_pass++;
            if ((k / FRAME == 1 || k / FRAME == 3) && k % SLOT >= BLANK) begin
                if (k / FRAME == 1) want_an = 8'hFF;
                else want_an = ((k % FRAME) / SLOT == 7) ? 8'hFF : ~(8'h01 << ((k % FRAME) / SLOT));
                n_total++;
                if (an_o !== want_an) $display("FAIL done_blink k=%0d got an=%h want %h", k, an_o, want_an);
                else n_pass++;
            end
        end
    endtask

    task automatic test_invalid();
        exp_t e;
        edit_i = 1'b0; done_i = 1'b0; curr_digit_i = '0; bcd_i = 36'h0000A0000;
        for (int k = 0; k < 2*FRAME; k++) begin
            step(); e = sb.pop_front();
            n_total++;
            if ({an_o, seg_o, dp_o} !== e)
                $display("FAIL invalid k=%0d got %h/%h/%b want %h/%h/%b", k, an_o, seg_o, dp_o, e.an, e.seg, e.dp);
            else n_pass++;
            if (k >= FRAME && k % SLOT >= BLANK) begin
                n_total++;
                if (seg_o !== (((k % FRAME) / SLOT == 3) ? 7'h3F : 7'h40))
                    $display("FAIL invalid_seg k=%0d got seg=%h", k, seg_o);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bcd_i = 36'h987654321;
        for (int k = 0; k < 19; k++) begin
            step(); e = sb.pop_front();
            n_total++;
            if ({an_o, seg_o, dp_o} !== e)
                $display("FAIL pre_rst k=%0d got %h/%h/%b want %h/%h/%b", k, an_o, seg_o, dp_o, e.an, e.seg, e.dp);
            else n_pass++;
        end
        rst = 1'b1;
        step(); e = sb.pop_front();
        n_total++;
        if ({an_o, seg_o, dp_o} !== {8'hFF, 7'h7F, 1'b1})
            $display("FAIL mid_reset got %h/%h/%b want FF/7F/1", an_o, seg_o, dp_o);
        else n_pass++;
        rst = 1'b0;
        for (int k = 0; k < 2*SLOT; k++) begin
            step(); e = sb.pop_front();
            n_total++;
            if ({an_o, seg_o, dp_o} !== e)
                $display("FAIL post_rst k=%0d got %h/%h/%b want %h/%h/%b", k, an_o, seg_o, dp_o, e.an, e.seg, e.dp);
            else n_pass++;
            if (k == 2 || k == SLOT + 2) begin
                n_total++;
                if (an_o !== ((k == 2) ? 8'hFE : 8'hFD) || seg_o !== 7'h40)
                    $display("FAIL restart k=%0d got an=%h seg=%h", k, an_o, seg_o);
                else n_pass++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; bcd_i = '0; edit_i = 1'b0; curr_digit_i = '0; done_i = 1'b0;
        m_j = 0; m_bcd = '0; m_edit = 1'b0; m_dig = '0; m_done = 1'b0;
        test_reset();
        test_value();
        test_tearing();
        test_edit();
        test_done();
        test_invalid();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
